rgb_stream_checker: RTL and testbench
=====================================

# rgb_stream_checker

Parametrised in-fabric checker for the VFP pixel path; successor to the single-width RGB assertion wrapper. Captures each valid RGB pixel from the camera-side bus into an expected-value FIFO, then compares it in order against each beat on the MM2S AXI-stream output. Maintains pixel, beat and mismatch counters, sticky overflow/underflow flags and a first-error snapshot. Sits beside the DUT in the VFP testbench and can also be synthesised as an on-chip monitor.

## Interface
- COLOR_W, 8, bits per colour channel
- TDATA_W, 32, AXI-stream data width; must be ≥ 3*COLOR_W (elaboration error otherwise)
- FIFO_DEPTH, 16, expected-pixel FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of all counters
- HALT_ON_ERR, 0, 1 = stop comparing after the first mismatch until `clr`
- TOL, 0, per-channel tolerance; used only when RGB_CHK_TOLERANCE_EN is defined
- pixclk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  gates both push and pop
- clr  in  1  synchronous clear of counters, flags, snapshot, FIFO and state
- valid  in  1  camera pixel valid
- iRed, iGreen, iBlue  in  COLOR_W each  camera pixel channels
- m_axis_mm2s_tvalid  in  1  output beat valid (checker is passive; no tready)
- m_axis_mm2s_tdata  in  TDATA_W  output beat; {R,G,B} in bits [3*COLOR_W-1:0], R at MSB; upper bits ignored
- pix_count, beat_count, err_count  out  CNT_W each  saturating counters
- mismatch  out  1  one-cycle pulse per failing compare
- overflow, underflow  out  1 each  sticky flags
- first_err_valid  out  1  snapshot valid
- first_err_exp, first_err_got  out  3*COLOR_W each  expected and received pixel of the first mismatch
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- halted  out  1  high in ST_HALT

## Operation
- Push = valid & enable & state≠ST_HALT. Pop = m_axis_mm2s_tvalid & enable & state≠ST_HALT.
- Push stores {iRed,iGreen,iBlue} and increments pix_count. Pop increments beat_count.
- Push when full without a pop: pixel dropped, overflow set. Push and pop together when full: both proceed, level unchanged.
- Pop when empty: underflow set, no compare, no err_count change. There is no bypass, so a push into an empty FIFO in the same cycle still counts as underflow.
- Compare on pop from non-empty: head versus tdata[3*COLOR_W-1:0]. A failing compare increments err_count and pulses mismatch. The first failure since reset/clr loads the snapshot and sets first_err_valid; later failures do not overwrite it.
- All counters saturate at all-ones.
- States:
  - ST_IDLE: enable=0; goes to ST_RUN when enable=1.
  - ST_RUN: goes to ST_IDLE when enable=0; goes to ST_HALT on a mismatch when HALT_ON_ERR=1.
  - ST_HALT: held until clr or reset.
- clr has priority over every other event in the same cycle and returns the block to ST_IDLE.

## Timing
- Reset and clr values: all counters 0, flags 0, snapshot 0, fifo_level 0, mismatch 0, halted 0, state ST_IDLE.
- Reset asserted mid-stream: FIFO contents discarded immediately (asynchronously).
- All outputs are registered.
- Counters, flags, fifo_level and snapshot reflect cycle N's push/pop at cycle N+1.
- mismatch is high in cycle N+1 for a failing compare in cycle N.
- halted rises in cycle N+1. A pop in cycle N+1 is already blocked.
- Back-to-back push/pop sustained at one per cycle.

## Configuration
- RGB_CHK_TOLERANCE_EN defined: a compare passes when every channel satisfies |exp−got| ≤ TOL, computed as an unsigned difference at COLOR_W+1 bits.
- Macro undefined: exact equality on all 3*COLOR_W bits; TOL ignored and no subtractor logic generated.

## Structure
- Package rgb_chk_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_HALT)
  - a pack_rgb function
  - the channel compare function (tolerance or exact, selected by the macro)
  - default width constants
- Sub-module rgb_chk_fifo: single-clock FIFO parameterised by width and depth, with full, empty and level outputs and an async active-low reset. The top level holds the control, counters and snapshot.

## Test plan
- Pass-through: 10 pixels with ramp R=G=B=i (i=0..9), each echoed two cycles later as tdata → pix_count=10, beat_count=10, err_count=0, fifo_level=0, first_err_valid=0.
- Single corruption: 3rd beat carries G=0x55 where 0x02 is expected → one mismatch pulse, err_count=1, first_err_exp=0x020202, first_err_got=0x025502.
- Halt: HALT_ON_ERR=1 with the above stimulus → halted=1 after the 3rd beat, beat_count=3, later beats ignored; clr → ST_IDLE with all counters 0.
- Overflow/underflow:
  - FIFO_DEPTH=4, 5 pushes without pops → overflow=1, pix_count=4, fifo_level=4.
  - Then a pop with level 0 after draining → underflow=1.
- Simultaneous events: full FIFO with push+pop in the same cycle → no overflow, level stays 4. Reset asserted mid-stream → all outputs 0 immediately.
- Tolerance (macro defined, TOL=1): expected 0x101010, got 0x111010 → no mismatch; got 0x121010 → err_count=1.

Source files
------------

// File: rtl/rgb_chk_pkg.sv
// rgb_chk_pkg: shared state type, default widths and pixel helpers for rgb_stream_checker.
// Build option RGB_CHK_TOLERANCE_EN selects the per-channel tolerant compare in rgb_match.
package rgb_chk_pkg;

  localparam int RGB_MAX_W      = 16;
  localparam int DEF_COLOR_W    = 8;
  localparam int DEF_TDATA_W    = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chk_state_e;

  typedef logic [RGB_MAX_W-1:0]   chan_t;
  typedef logic [3*RGB_MAX_W-1:0] rgb_wide_t;

  // Packs three channels of width w as {R,G,B}, R at the most significant end.
  function automatic rgb_wide_t pack_rgb(input chan_t r, input chan_t g, input chan_t b,
                                         input int unsigned w);
    rgb_wide_t r_v;
    rgb_wide_t g_v;
    rgb_wide_t b_v;
    r_v = rgb_wide_t'(r);
    g_v = rgb_wide_t'(g);
    b_v = rgb_wide_t'(b);
    return (r_v << (32'd2 * w)) | (g_v << w) | b_v;
  endfunction

`ifdef RGB_CHK_TOLERANCE_EN
  // Every channel must satisfy |e-g| <= tol; channels are zero-extended so the
  // difference is exact for any w up to RGB_MAX_W.
  function automatic logic rgb_match(input rgb_wide_t e, input rgb_wide_t g,
                                     input int unsigned w, input int unsigned tol);
    rgb_wide_t          mask_v;
    chan_t              e_c;
    chan_t              g_c;
    logic [RGB_MAX_W:0] diff_v;
    logic               ok_v;
    mask_v = (rgb_wide_t'(1'b1) << w) - rgb_wide_t'(1'b1);
    ok_v   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e_c = chan_t'((e >> (w * k)) & mask_v);
      g_c = chan_t'((g >> (w * k)) & mask_v);
      if (e_c >= g_c) begin
        diff_v = {1'b0, e_c} - {1'b0, g_c};
      end else begin
        diff_v = {1'b0, g_c} - {1'b0, e_c};
      end
      ok_v = ok_v & (32'(diff_v) <= tol);
    end
    return ok_v;
  endfunction
`else
  function automatic logic rgb_match(input rgb_wide_t e, input rgb_wide_t g);
    return (e == g);
  endfunction
`endif

endpackage

// File: rtl/rgb_chk_fifo.sv
// rgb_chk_fifo: single-clock expected-pixel FIFO. No read bypass: a pop is
// honoured only when an entry was already stored; a push into a full FIFO needs a pop.
module rgb_chk_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     wr_ok,
  output logic                     rd_ok,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;

  assign empty = (level_r == {LW{1'b0}});
  assign full  = (level_r == LW'(DEPTH));
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;

  // pointers and occupancy; reset discards contents by clearing level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (srst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (wr_ok) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (rd_ok) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({wr_ok, rd_ok})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // storage array; entries beyond level are never read, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/rgb_stream_checker.sv
// rgb_stream_checker: compares camera pixels, in order, against MM2S stream beats.
// Define RGB_CHK_TOLERANCE_EN to accept per-channel differences up to TOL.
module rgb_stream_checker
  import rgb_chk_pkg::*;
#(
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int TDATA_W     = DEF_TDATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit HALT_ON_ERR = 1'b0,
  parameter int TOL         = 0
) (
  input  logic                          pixclk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          clr,
  input  logic                          valid,
  input  logic [COLOR_W-1:0]            iRed,
  input  logic [COLOR_W-1:0]            iGreen,
  input  logic [COLOR_W-1:0]            iBlue,
  input  logic                          m_axis_mm2s_tvalid,
  input  logic [TDATA_W-1:0]            m_axis_mm2s_tdata,
  output logic [CNT_W-1:0]              pix_count,
  output logic [CNT_W-1:0]              beat_count,
  output logic [CNT_W-1:0]              err_count,
  output logic                          mismatch,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          first_err_valid,
  output logic [3*COLOR_W-1:0]          first_err_exp,
  output logic [3*COLOR_W-1:0]          first_err_got,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          halted
);

  localparam int PIX_W = 3 * COLOR_W;

  if (TDATA_W < PIX_W) begin : g_bad_tdata
    $error("rgb_stream_checker: TDATA_W must be at least 3*COLOR_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rgb_stream_checker: FIFO_DEPTH must be a power of two >= 2");
  end
  if (COLOR_W > RGB_MAX_W) begin : g_bad_color
    $error("rgb_stream_checker: COLOR_W exceeds RGB_MAX_W");
  end
  if (TDATA_W > PIX_W) begin : g_tdata_pad
    logic unused_tdata_s;
    assign unused_tdata_s = ^m_axis_mm2s_tdata[TDATA_W-1:PIX_W];
  end

  chk_state_e       state_r;
  chk_state_e       next_state_s;
  logic             push_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_s;
  logic             empty_s;
  logic [PIX_W-1:0] pix_in_s;
  logic [PIX_W-1:0] head_s;
  logic [PIX_W-1:0] got_s;
  logic             match_s;
  logic             fail_s;
  logic             ovf_s;
  logic             udf_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1'b1);
    end
  endfunction

  assign push_s   = valid & enable & (state_r != ST_HALT);
  assign pop_s    = m_axis_mm2s_tvalid & enable & (state_r != ST_HALT);
  assign pix_in_s = PIX_W'(pack_rgb(chan_t'(iRed), chan_t'(iGreen), chan_t'(iBlue),
                                    COLOR_W));
  assign got_s    = m_axis_mm2s_tdata[PIX_W-1:0];

`ifdef RGB_CHK_TOLERANCE_EN
  assign match_s = rgb_match(rgb_wide_t'(head_s), rgb_wide_t'(got_s), COLOR_W, TOL);
`else
  localparam int unused_tol = TOL;
  assign match_s = rgb_match(rgb_wide_t'(head_s), rgb_wide_t'(got_s));
`endif

  // an empty-FIFO pop never compares, even if a push lands in the same cycle
  assign fail_s = pop_ok_s & ~match_s;
  assign ovf_s  = push_s & ~push_ok_s;
  assign udf_s  = pop_s & empty_s;

  rgb_chk_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixclk),
    .rst_n (resetn),
    .srst  (clr),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pix_in_s),
    .head  (head_s),
    .wr_ok (push_ok_s),
    .rd_ok (pop_ok_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) next_state_s = ST_RUN;
        else        next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable)                  next_state_s = ST_IDLE;
        else if (HALT_ON_ERR && fail_s) next_state_s = ST_HALT;
        else                          next_state_s = ST_RUN;
      end
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // state, counters, sticky flags and first-error snapshot; clr outranks everything
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      state_r         <= ST_IDLE;
      halted          <= 1'b0;
      mismatch        <= 1'b0;
      pix_count       <= {CNT_W{1'b0}};
      beat_count      <= {CNT_W{1'b0}};
      err_count       <= {CNT_W{1'b0}};
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_exp   <= {PIX_W{1'b0}};
      first_err_got   <= {PIX_W{1'b0}};
    end else if (clr) begin
      state_r         <= ST_IDLE;
      halted          <= 1'b0;
      mismatch        <= 1'b0;
      pix_count       <= {CNT_W{1'b0}};
      beat_count      <= {CNT_W{1'b0}};
      err_count       <= {CNT_W{1'b0}};
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_exp   <= {PIX_W{1'b0}};
      first_err_got   <= {PIX_W{1'b0}};
    end else begin
      state_r  <= next_state_s;
      halted   <= (next_state_s == ST_HALT);
      mismatch <= fail_s;
      if (push_ok_s) pix_count  <= sat_inc(pix_count);
      if (pop_s)     beat_count <= sat_inc(beat_count);
      if (fail_s)    err_count  <= sat_inc(err_count);
      if (ovf_s)     overflow   <= 1'b1;
      if (udf_s)     underflow  <= 1'b1;
      if (fail_s && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_exp   <= head_s;
        first_err_got   <= got_s;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_checker.sv
// Scoreboard bench for rgb_stream_checker: expected pixels queue at drive time,
// per-beat mismatch expectations are popped and compared one cycle later.
module tb_rgb_stream_checker;

  localparam int TB_TOL = 1;

  logic        pixclk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        clr;
  logic        valid;
  logic [7:0]  iRed, iGreen, iBlue;
  logic        tvalid;
  logic [31:0] tdata;

  logic [15:0] pix_a, beat_a, err_a, pix_h, beat_h, err_h;
  logic        mm_a, ovf_a, udf_a, fev_a, halt_a, mm_h, ovf_h, udf_h, fev_h, halt_h;
  logic [23:0] fexp_a, fgot_a, fexp_h, fgot_h;
  logic [4:0]  lvl_a;
  logic [2:0]  lvl_h;

  rgb_stream_checker #(.TOL(TB_TOL)) dut_a (
    .pixclk(pixclk), .resetn(resetn), .enable(enable), .clr(clr), .valid(valid),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tdata(tdata),
    .pix_count(pix_a), .beat_count(beat_a), .err_count(err_a), .mismatch(mm_a),
    .overflow(ovf_a), .underflow(udf_a), .first_err_valid(fev_a),
    .first_err_exp(fexp_a), .first_err_got(fgot_a), .fifo_level(lvl_a), .halted(halt_a)
  );

  rgb_stream_checker #(.FIFO_DEPTH(4), .HALT_ON_ERR(1'b1), .TOL(TB_TOL)) dut_h (
    .pixclk(pixclk), .resetn(resetn), .enable(enable), .clr(clr), .valid(valid),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tdata(tdata),
    .pix_count(pix_h), .beat_count(beat_h), .err_count(err_h), .mismatch(mm_h),
    .overflow(ovf_h), .underflow(udf_h), .first_err_valid(fev_h),
    .first_err_exp(fexp_h), .first_err_got(fgot_h), .fifo_level(lvl_h), .halted(halt_h)
  );

  always #5 pixclk = ~pixclk;

  bit sel_h = 1'b0;
  wire [15:0] pix_o  = sel_h ? pix_h  : pix_a;
  wire [15:0] beat_o = sel_h ? beat_h : beat_a;
  wire [15:0] err_o  = sel_h ? err_h  : err_a;
  wire        mm_o   = sel_h ? mm_h   : mm_a;
  wire        ovf_o  = sel_h ? ovf_h  : ovf_a;
  wire        udf_o  = sel_h ? udf_h  : udf_a;
  wire        fev_o  = sel_h ? fev_h  : fev_a;
  wire        halt_o = sel_h ? halt_h : halt_a;
  wire [23:0] fexp_o = sel_h ? fexp_h : fexp_a;
  wire [23:0] fgot_o = sel_h ? fgot_h : fgot_a;
  wire [4:0]  lvl_o  = sel_h ? {2'b00, lvl_h} : lvl_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [23:0] exp_q[$];
  bit          mm_q[$];
  int          m_depth;
  bit          m_halt_mode;
  int          m_pix, m_beat, m_err;
  bit          m_ovf, m_udf, m_fev, m_halted;
  logic [23:0] m_fexp, m_fgot;

  task automatic model_reset();
    exp_q.delete();
    mm_q.delete();
    m_pix = 0; m_beat = 0; m_err = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_fev = 1'b0; m_halted = 1'b0;
    m_fexp = 24'h0; m_fgot = 24'h0;
  endtask

  function automatic bit model_match(input logic [23:0] e, input logic [23:0] g);
`ifdef RGB_CHK_TOLERANCE_EN
    for (int k = 0; k < 3; k++) begin
      int de = int'(e[8*k +: 8]);
      int dg = int'(g[8*k +: 8]);
      int d  = (de > dg) ? de - dg : dg - de;
      if (d > TB_TOL) return 1'b0;
    end
    return 1'b1;
`else
    return e == g;
`endif
  endfunction

  // one clock: drive at negedge, model the cycle, sample at the next negedge
  task automatic drive_cycle(input bit v, input logic [23:0] pix, input bit tv,
                             input logic [23:0] beat);
    bit          fail = 1'b0;
    bit          did_pop = 1'b0;
    bit          full_b;
    logic [23:0] e;
    valid  = v;
    {iRed, iGreen, iBlue} = pix;
    tvalid = tv;
    tdata  = {8'($urandom), beat};
    full_b = (exp_q.size() >= m_depth);
    if (tv && enable && !m_halted) begin
      m_beat++;
      if (exp_q.size() == 0) begin
        m_udf = 1'b1;
      end else begin
        e = exp_q.pop_front();
        did_pop = 1'b1;
        if (!model_match(e, beat)) begin
          fail = 1'b1;
          m_err++;
          if (!m_fev) begin
            m_fev = 1'b1; m_fexp = e; m_fgot = beat;
          end
        end
      end
    end
    if (v && enable && !m_halted) begin
      if (!full_b || did_pop) begin
        exp_q.push_back(pix);
        m_pix++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (fail && m_halt_mode) m_halted = 1'b1;
    mm_q.push_back(fail);
    @(posedge pixclk);
    @(negedge pixclk);
    check_eq("mismatch", 64'(mm_o), 64'(mm_q.pop_front()));
    check_eq("fifo_level", 64'(lvl_o), 64'(exp_q.size()));
    check_eq("halted", 64'(halt_o), 64'(m_halted));
  endtask

  task automatic check_model();
    check_eq("pix_count", 64'(pix_o), 64'(m_pix));
    check_eq("beat_count", 64'(beat_o), 64'(m_beat));
    check_eq("err_count", 64'(err_o), 64'(m_err));
    check_eq("overflow", 64'(ovf_o), 64'(m_ovf));
    check_eq("underflow", 64'(udf_o), 64'(m_udf));
    check_eq("first_err_valid", 64'(fev_o), 64'(m_fev));
    check_eq("first_err_exp", 64'(fexp_o), 64'(m_fexp));
    check_eq("first_err_got", 64'(fgot_o), 64'(m_fgot));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pix"}, 64'(pix_o), 64'h0);
    check_eq({tag, "_beat"}, 64'(beat_o), 64'h0);
    check_eq({tag, "_err"}, 64'(err_o), 64'h0);
    check_eq({tag, "_flags"}, 64'({mm_o, ovf_o, udf_o, fev_o, halt_o}), 64'h0);
    check_eq({tag, "_snap"}, 64'({fexp_o, fgot_o}), 64'h0);
    check_eq({tag, "_level"}, 64'(lvl_o), 64'h0);
  endtask

  task automatic do_clr();
    valid = 1'b0; tvalid = 1'b0; clr = 1'b1;
    @(posedge pixclk);
    @(negedge pixclk);
    clr = 1'b0;
    model_reset();
    check_all_zero("clr");
    drive_cycle(1'b0, 24'h0, 1'b0, 24'h0);
  endtask

  // ramp pixels R=G=B=t, each echoed two cycles later; optional green corruption
  task automatic run_ramp(input int corrupt_idx);
    for (int t = 0; t < 12; t++) begin
      logic [23:0] b;
      b = {3{8'(t - 2)}};
      if (t - 2 == corrupt_idx) b[15:8] = 8'h55;
      drive_cycle(t < 10, {3{8'(t)}}, t >= 2, b);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; clr = 1'b0; valid = 1'b0; tvalid = 1'b0;
    iRed = 8'h0; iGreen = 8'h0; iBlue = 8'h0; tdata = 32'h0;
    m_depth = 16; m_halt_mode = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge pixclk);
    resetn = 1'b1;

    // disabled: a valid pixel is ignored
    drive_cycle(1'b1, 24'h123456, 1'b0, 24'h0);
    check_eq("disabled_pix", 64'(pix_o), 64'h0);
    enable = 1'b1;

    // pass-through on the default instance
    sel_h = 1'b0; m_depth = 16; m_halt_mode = 1'b0;
    do_clr();
    run_ramp(-1);
    check_model();
    check_eq("pt_pix", 64'(pix_o), 64'd10);
    check_eq("pt_beat", 64'(beat_o), 64'd10);

    // single corruption
    do_clr();
    run_ramp(2);
    check_model();
    check_eq("corr_err", 64'(err_o), 64'd1);
    check_eq("corr_exp", 64'(fexp_o), 64'h020202);
    check_eq("corr_got", 64'(fgot_o), 64'h025502);

    // halt on error instance
    sel_h = 1'b1; m_depth = 4; m_halt_mode = 1'b1;
    do_clr();
    run_ramp(2);
    check_model();
    check_eq("halt_flag", 64'(halt_o), 64'd1);
    check_eq("halt_beat", 64'(beat_o), 64'd3);
    do_clr();
    check_eq("halt_cleared", 64'(halt_o), 64'd0);

    // overflow with depth 4
    do_clr();
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 24'h0A0B00 + 24'(k), 1'b0, 24'h0);
    check_model();
    check_eq("ovf_flag", 64'(ovf_o), 64'd1);
    check_eq("ovf_pix", 64'(pix_o), 64'd4);
    check_eq("ovf_level", 64'(lvl_o), 64'd4);

    // simultaneous push+pop when full, then drain and underflow
    do_clr();
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 24'h0C0D00 + 24'(k), 1'b0, 24'h0);
    drive_cycle(1'b1, 24'h0C0D04, 1'b1, exp_q[0]);
    check_eq("pp_ovf", 64'(ovf_o), 64'd0);
    check_eq("pp_level", 64'(lvl_o), 64'd4);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 24'h0, 1'b1, exp_q[0]);
    check_eq("drain_udf", 64'(udf_o), 64'd0);
    drive_cycle(1'b0, 24'h0, 1'b1, 24'h0);
    check_model();
    check_eq("udf_flag", 64'(udf_o), 64'd1);

    // reset mid-stream clears outputs without a clock edge
    sel_h = 1'b0; m_depth = 16; m_halt_mode = 1'b0;
    do_clr();
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 24'h202020 + 24'(k), 1'b0, 24'h0);
    check_eq("pre_reset_level", 64'(lvl_o), 64'd3);
    #2 resetn = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge pixclk);
    resetn = 1'b1;
    drive_cycle(1'b0, 24'h0, 1'b0, 24'h0);

    // tolerance boundary
    do_clr();
    drive_cycle(1'b1, 24'h101010, 1'b0, 24'h0);
    drive_cycle(1'b0, 24'h0, 1'b1, 24'h111010);
    drive_cycle(1'b1, 24'h101010, 1'b0, 24'h0);
    drive_cycle(1'b0, 24'h0, 1'b1, 24'h121010);
    drive_cycle(1'b0, 24'h0, 1'b0, 24'h0);
    check_model();
`ifdef RGB_CHK_TOLERANCE_EN
    check_eq("tol_err", 64'(err_o), 64'd1);
    check_eq("tol_got", 64'(fgot_o), 64'h121010);
`else
    check_eq("exact_err", 64'(err_o), 64'd2);
    check_eq("exact_got", 64'(fgot_o), 64'h111010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
